// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with byte strobes, bypass and busy scoreboard
//
// Purpose: register file for the MIPS core. Two byte-strobed write ports
// (port 1 wins per byte over port 0), NUM_READ combinational read ports with
// optional same-cycle write forwarding, and one busy bit per register so
// issue logic can stall on outstanding producers. Register 0 reads as zero,
// ignores writes and is never busy.
//
// Ports:
//   clk                          rising-edge clock
//   rst                          asynchronous active-low reset
//   wen0/waddr0/wstrb0/wdata0    write port 0
//   wen1/waddr1/wstrb1/wdata1    write port 1 (higher priority per byte)
//   raddr                        flattened read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata                        flattened read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy                        busy bit of each read address
//   sb_set/sb_addr               mark a register busy when its producer issues
//   any_busy                     OR of all busy bits
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wen0,
    input  logic [ADDR_WIDTH-1:0]          waddr0,
    input  logic [DATA_WIDTH/8-1:0]        wstrb0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic                           wen1,
    input  logic [ADDR_WIDTH-1:0]          waddr1,
    input  logic [DATA_WIDTH/8-1:0]        wstrb1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           sb_set,
    input  logic [ADDR_WIDTH-1:0]          sb_addr,
    output logic                           any_busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("reg_file_mp: NUM_READ must be in 1..4");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("reg_file_mp: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // Port 1 is applied after port 0 so its strobed bytes overwrite port 0's
    // on an address collision; bytes only port 0 strobes survive.
    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < NBYTES; b++) begin
            if (wen0 && waddr0 != '0 && wstrb0[b]) begin
                regs_d[waddr0][b*8 +: 8] = wdata0[b*8 +: 8];
            end
            if (wen1 && waddr1 != '0 && wstrb1[b]) begin
                regs_d[waddr1][b*8 +: 8] = wdata1[b*8 +: 8];
            end
        end
        regs_d[0] = '0;
    end

    // Commit clears, then a new producer's set is applied last so it wins
    // when both target the same register in one cycle. A commit counts even
    // when no strobe bit is set.
    always_comb begin
        busy_d = busy_q;
        if (wen0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (wen1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] val;

        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Forwarding mirrors the write priority byte by byte so a read sees
        // exactly what the register will hold after the edge.
        always_comb begin
            val = regs_q[ra];
            if (BYPASS != 0) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wen1 && waddr1 == ra && wstrb1[b]) begin
                        val[b*8 +: 8] = wdata1[b*8 +: 8];
                    end else if (wen0 && waddr0 == ra && wstrb0[b]) begin
                        val[b*8 +: 8] = wdata0[b*8 +: 8];
                    end
                end
            end
            if (ra == '0) begin
                val = '0;
            end
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = val;
        // Busy is reported from the stored bits only; a commit in this cycle
        // is not forwarded.
        assign rbusy[i] = busy_q[ra];
    end

    assign any_busy = |busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (BYPASS=1 and BYPASS=0 instances)
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wen0, wen1, sb_set;
    logic [AW-1:0]  waddr0, waddr1, sb_addr;
    logic [3:0]     wstrb0, wstrb1;
    logic [DW-1:0]  wdata0, wdata1;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    rbusy_b, rbusy_n;
    logic             any_b, any_n;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_b)
    );

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_n)
    );

    task automatic idle();
        wen0 = 0; waddr0 = '0; wstrb0 = '0; wdata0 = '0;
        wen1 = 0; waddr1 = '0; wstrb1 = '0; wdata1 = '0;
        sb_set = 0; sb_addr = '0; raddr = '0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            m_reg[a] = '0;
            m_busy[a] = 0;
        end
    endtask

    // Value register a would show: stored contents, optionally with the
    // pending writes merged byte by byte (port 1 over port 0).
    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_reg[a];
        if (byp) begin
            for (int b = 0; b < 4; b++) begin
                if (wen1 && int'(waddr1) == a && wstrb1[b]) v[b*8 +: 8] = wdata1[b*8 +: 8];
                else if (wen0 && int'(waddr0) == a && wstrb0[b]) v[b*8 +: 8] = wdata0[b*8 +: 8];
            end
        end
        return v;
    endfunction

    function automatic bit exp_any();
        bit r = 0;
        for (int a = 0; a < 32; a++) r |= m_busy[a];
        return r;
    endfunction

    task automatic model_commit();
        logic [31:0] nr [32];
        for (int a = 0; a < 32; a++) nr[a] = exp_rd(a, 1);
        for (int a = 1; a < 32; a++) begin
            m_reg[a] = nr[a];
            if (sb_set && int'(sb_addr) == a) m_busy[a] = 1;
            else if ((wen0 && int'(waddr0) == a) || (wen1 && int'(waddr1) == a)) m_busy[a] = 0;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        for (int a = 0; a < 32; a++) begin
            raddr = {a[AW-1:0], a[AW-1:0]};
            #1;
            checks++;
            if (rdata_b !== '0 || rdata_n !== '0) begin
                failures++;
                $display("FAIL reset_rdata a=%0d got=%h/%h exp=0", a, rdata_b, rdata_n);
            end
            checks++;
            if (rbusy_b !== '0 || rbusy_n !== '0 || any_b !== 1'b0 || any_n !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy a=%0d got=%b/%b any=%b/%b exp=0", a, rbusy_b, rbusy_n, any_b, any_n);
            end
        end
        // Reset asserted while a write is set up: the edge must not load it.
        @(posedge clk); #1;
        wen0 = 1; waddr0 = 5; wstrb0 = 4'hF; wdata0 = 32'hDEADBEEF;
        sb_set = 1; sb_addr = 5;
        #2 rst = 0;
        @(posedge clk); #1;
        idle();
        #2 rst = 1;
        model_reset();
        raddr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'h0 || rdata_n[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_midwrite got=%h/%h exp=0", rdata_b[31:0], rdata_n[31:0]);
        end
        checks++;
        if (any_b !== 1'b0 || any_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_midwrite_busy got=%b/%b exp=0", any_b, any_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_strobe();
        idle();
        wen0 = 1; waddr0 = 3; wstrb0 = 4'b1111; wdata0 = 32'h12345678;
        tick();
        wstrb0 = 4'b0010; wdata0 = 32'h0000AB00;
        tick();
        idle();
        raddr = {5'd3, 5'd3};
        #1;
        checks++;
        if (rdata_n[31:0] !== 32'h1234AB78 || rdata_b[63:32] !== 32'h1234AB78) begin
            failures++;
            $display("FAIL strobe_merge got=%h/%h exp=1234ab78", rdata_n[31:0], rdata_b[63:32]);
        end
    endtask

    task automatic test_same_addr();
        idle();
        wen0 = 1; waddr0 = 7; wstrb0 = 4'b1111; wdata0 = 32'h11111111;
        wen1 = 1; waddr1 = 7; wstrb1 = 4'b0011; wdata1 = 32'h22222222;
        raddr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'h11112222 || rdata_n[31:0] !== exp_rd(7, 0)) begin
            failures++;
            $display("FAIL same_addr_pre got=%h/%h exp=11112222/%h", rdata_b[31:0], rdata_n[31:0], exp_rd(7, 0));
        end
        tick();
        idle();
        raddr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'h11112222 || rdata_n[63:32] !== 32'h11112222) begin
            failures++;
            $display("FAIL same_addr_post got=%h/%h exp=11112222", rdata_b[31:0], rdata_n[63:32]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wen0 = 1; waddr0 = 9; wstrb0 = 4'hF; wdata0 = 32'hCAFEF00D;
        raddr = {5'd9, 5'd9};
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bypass_fwd got=%h exp=cafef00d", rdata_b[31:0]);
        end
        checks++;
        if (rdata_n[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_old got=%h exp=0", rdata_n[31:0]);
        end
        tick();
        idle();
        raddr = {5'd9, 5'd9};
        #1;
        checks++;
        if (rdata_n[31:0] !== 32'hCAFEF00D || rdata_b[31:0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bypass_post got=%h/%h exp=cafef00d", rdata_b[31:0], rdata_n[31:0]);
        end
    endtask

    task automatic test_r0();
        idle();
        wen0 = 1; waddr0 = 0; wstrb0 = 4'hF; wdata0 = 32'hFFFFFFFF;
        wen1 = 1; waddr1 = 0; wstrb1 = 4'hF; wdata1 = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rdata_b !== '0 || rdata_n !== '0) begin
            failures++;
            $display("FAIL r0_bypass got=%h/%h exp=0", rdata_b, rdata_n);
        end
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr = {a[AW-1:0], a[AW-1:0]};
            #1;
            checks++;
            if (rdata_b[31:0] !== exp_rd(a, 0) || rdata_n[63:32] !== exp_rd(a, 0)) begin
                failures++;
                $display("FAIL r0_nochange a=%0d got=%h/%h exp=%h", a, rdata_b[31:0], rdata_n[63:32], exp_rd(a, 0));
            end
        end
    endtask

    task automatic test_scoreboard();
        idle();
        sb_set = 1; sb_addr = 4;
        raddr = {5'd0, 5'd4};
        #1;
        checks++;
        if (rbusy_b[0] !== 1'b0 || any_b !== 1'b0) begin
            failures++;
            $display("FAIL sb_before got=%b any=%b exp=0", rbusy_b[0], any_b);
        end
        tick();
        idle();
        raddr = {5'd0, 5'd4};
        #1;
        checks++;
        if (rbusy_b !== 2'b01 || rbusy_n !== 2'b01 || any_b !== 1'b1 || any_n !== 1'b1) begin
            failures++;
            $display("FAIL sb_set got=%b/%b any=%b/%b exp=01/1", rbusy_b, rbusy_n, any_b, any_n);
        end
        sb_set = 1; sb_addr = 4;
        wen1 = 1; waddr1 = 4; wstrb1 = 4'b0000; wdata1 = 32'h55555555;
        tick();
        idle();
        raddr = {5'd4, 5'd4};
        #1;
        checks++;
        if (rbusy_b !== 2'b11 || any_n !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins got=%b any=%b exp=11/1", rbusy_b, any_n);
        end
        wen1 = 1; waddr1 = 4; wstrb1 = 4'b0000; wdata1 = 32'h55555555;
        #1;
        checks++;
        if (rbusy_n !== 2'b11) begin
            failures++;
            $display("FAIL sb_no_commit_bypass got=%b exp=11", rbusy_n);
        end
        tick();
        idle();
        raddr = {5'd4, 5'd4};
        #1;
        checks++;
        if (rbusy_b !== 2'b00 || any_b !== 1'b0 || any_n !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear got=%b any=%b/%b exp=00/0", rbusy_b, any_b, any_n);
        end
        checks++;
        if (rdata_b[31:0] !== exp_rd(4, 0)) begin
            failures++;
            $display("FAIL sb_zero_strobe_data got=%h exp=%h", rdata_b[31:0], exp_rd(4, 0));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            idle();
            wen0 = 1'($urandom_range(0, 1));
            wen1 = 1'($urandom_range(0, 1));
            waddr0 = AW'($urandom_range(0, 7));
            waddr1 = AW'($urandom_range(0, 7));
            wstrb0 = 4'($urandom);
            wstrb1 = 4'($urandom);
            wdata0 = $urandom;
            wdata1 = $urandom;
            sb_set = ($urandom_range(0, 3) == 0);
            sb_addr = AW'($urandom_range(0, 7));
            raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int i = 0; i < NR; i++) begin
                int a;
                a = int'(raddr[i*AW +: AW]);
                checks++;
                if (rdata_b[i*DW +: DW] !== exp_rd(a, 1)) begin
                    failures++;
                    $display("FAIL rand_byp n=%0d port=%0d a=%0d got=%h exp=%h", n, i, a, rdata_b[i*DW +: DW], exp_rd(a, 1));
                end
                checks++;
                if (rdata_n[i*DW +: DW] !== exp_rd(a, 0)) begin
                    failures++;
                    $display("FAIL rand_nob n=%0d port=%0d a=%0d got=%h exp=%h", n, i, a, rdata_n[i*DW +: DW], exp_rd(a, 0));
                end
                checks++;
                if (rbusy_b[i] !== m_busy[a] || rbusy_n[i] !== m_busy[a]) begin
                    failures++;
                    $display("FAIL rand_busy n=%0d port=%0d a=%0d got=%b/%b exp=%b", n, i, a, rbusy_b[i], rbusy_n[i], m_busy[a]);
                end
            end
            checks++;
            if (any_b !== exp_any() || any_n !== exp_any()) begin
                failures++;
                $display("FAIL rand_any n=%0d got=%b/%b exp=%b", n, any_b, any_n, exp_any());
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_strobe();
        test_same_addr();
        test_bypass();
        test_r0();
        test_scoreboard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the next single-cycle/pipelined MIPS core.
- Two write ports with byte strobes and a configurable number of read ports, with optional same-cycle write-to-read bypass.
- Per-register busy scoreboard so issue logic can stall on pending producers.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the matching read port; 0 = read returns the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wen0  in  1  write enable, port 0.
- waddr0  in  ADDR_WIDTH  write address, port 0.
- wstrb0  in  DATA_WIDTH/8  byte strobes, port 0.
- wdata0  in  DATA_WIDTH  write data, port 0.
- wen1, waddr1, wstrb1, wdata1  in  same as port 0  write port 1 (higher priority).
- raddr  in  NUM_READ*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_READ*DATA_WIDTH  read data, flattened the same way.
- rbusy  out  NUM_READ  busy bit of each read address.
- sb_set  in  1  mark register sb_addr busy (producer issued).
- sb_addr  in  ADDR_WIDTH  scoreboard set address.
- any_busy  out  1  OR of all busy bits.

Behaviour:
Reset
- While rst==0, all registers and busy bits are 0 immediately; this overrides any clock edge in progress.
- Out of reset: rdata = 0, rbusy = 0, any_busy = 0.

Writes
- On posedge, for port k with wenk==1 and waddrk!=0: each byte b with wstrbk[b]==1 is loaded from wdatak. Unstrobed bytes hold.
- Both ports to the same address: resolved per byte. Port 1's strobed bytes win; port 0 supplies bytes only port 0 strobes; neither strobed = hold.
- Writes to address 0 are ignored on both ports; register 0 always reads 0.
- wenk==1 with wstrbk==0 writes no data but still counts as a commit for the scoreboard.

Reads
- Combinational, zero latency. raddr==0 returns 0 regardless of bypass.
- BYPASS=1: forward pending writes byte-by-byte into the stored value using the same priority as the write (port 1 over port 0).
- BYPASS=0: return the stored value only; new data is visible the cycle after the edge.

Scoreboard (one busy bit per register, reg 0 never busy)
- Set on posedge when sb_set==1 and sb_addr!=0.
- Cleared on posedge when either write port commits (wenk==1) to that address.
- Set and commit to the same address in the same cycle: set wins (new producer supersedes the retiring one); busy stays 1.
- rbusy[i] = busy[raddr_i], combinational, no bypass of a same-cycle commit.
- any_busy is combinational from the busy bits.

Illegal configurations
- NUM_READ outside 1..4, or DATA_WIDTH not a multiple of 8, stops elaboration via a generate-time error.

Test Plan:
- Reset then read all addresses -> rdata=0, rbusy=0, any_busy=0. Assert rst=0 mid-write of 0xDEADBEEF to r5 -> r5 reads 0 after release.
- wen0=1, waddr0=3, wstrb0=4'b1111, wdata0=0x12345678; next cycle wstrb0=4'b0010, wdata0=0x0000AB00 -> r3 reads 0x1234AB78.
- Same edge: port0 writes r7=0x11111111 strb 1111, port1 writes r7=0x22222222 strb 0011 -> r7=0x11112222.
- BYPASS=1: write r9=0xCAFEF00D with raddr port0=9 in the same cycle -> rdata0=0xCAFEF00D before the edge. BYPASS=0 -> old value (0) until after the edge.
- Write 0xFFFFFFFF to r0 on both ports -> r0 reads 0, no change anywhere else.
- sb_set r4 -> rbusy=1 and any_busy=1 next cycle. sb_set r4 plus wen1 commit to r4 in the same cycle -> still busy. Commit alone next cycle -> busy 0, any_busy 0.
